axis_bk_arbiter: RTL and testbench
==================================

AXIS_BK_ARBITER -- requirements
Module: axis_bk_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 3: number of requesters, range 2..4.
REQ-002 Parameter MAX_BEATS, default 6: maximum beats per grant; the downstream FIFO holds 7 entries.
REQ-003 Parameter DRAIN_TIMEOUT, default 8'd64: maximum cycles to wait for bk_done.
REQ-004 axi_aclk  in  1  sole clock; all logic is rising-edge.
REQ-005 axi_aresetn  in  1  asynchronous active-low reset.
REQ-006 req_valid  in  NUM_REQ  per-requester beat valid.
REQ-007 req_data  in  NUM_REQ*32  per-requester data; requester i uses slice [32i+31:32i].
REQ-008 req_tstrb, req_tkeep  in  NUM_REQ*4 each  per-requester byte qualifiers.
REQ-009 req_last  in  NUM_REQ  marks the last beat of a packet.
REQ-010 req_ready  out  NUM_REQ  beat accepted when req_valid[i] and req_ready[i] are both high.
REQ-011 grant  out  NUM_REQ  one-hot current owner; all zero when no requester owns the backend.
REQ-012 bk_start  out  1  downstream beat write strobe.
REQ-013 bk_data, bk_tstrb, bk_tkeep, bk_user  out  32/4/4/2  downstream beat fields.
REQ-014 bk_nordy  in  1  downstream back-pressure indication.
REQ-015 bk_done  in  1  one-cycle downstream transaction-complete pulse.
REQ-016 err_timeout  out  1  sticky drain-timeout flag.
REQ-017 err_clr  in  1  synchronous clear of err_timeout.

Function
REQ-018 The FSM SHALL have three states: IDLE, XFER and DRAIN.
REQ-019 IDLE: if any req_valid is high, the block SHALL select the first requester at or after rr_ptr, searching in ascending index order with modulo wrap.
REQ-020 On that selection, the block SHALL register grant and move to XFER on the next edge; the next edge is also when grant becomes visible.
REQ-021 No beat SHALL be accepted in the IDLE cycle; latency from req_valid to the first req_ready is 1 cycle minimum.
REQ-022 XFER: req_ready[g] SHALL equal ~bk_nordy, combinationally.
REQ-023 XFER: bk_start SHALL equal req_valid[g] & ~bk_nordy.
REQ-024 XFER: all other req_ready bits SHALL be 0.
REQ-025 XFER: bk_data, bk_tstrb and bk_tkeep SHALL be the slices of requester g.
REQ-026 XFER: bk_user SHALL equal g[1:0].
REQ-027 When bk_start is 0, bk_data, bk_tstrb, bk_tkeep and bk_user SHALL be 0.
REQ-028 beat_cnt (4 bits) SHALL clear on entry to XFER and increment on each accepted beat.
REQ-029 An accepted beat with req_last=1 SHALL move the FSM to DRAIN.
REQ-030 An accepted beat that brings beat_cnt to MAX_BEATS SHALL move the FSM to DRAIN, splitting the packet; the remainder re-arbitrates normally.
REQ-031 When both end conditions of REQ-029 and REQ-030 coincide, the FSM SHALL take a single transition to DRAIN.
REQ-032 XFER with req_valid[g]=0 SHALL hold state, with no timeout.
REQ-033 DRAIN: all req_ready SHALL be 0, bk_start SHALL be 0, and grant SHALL be held.
REQ-034 DRAIN: drain_cnt (8 bits) SHALL count cycles from 0.
REQ-035 In DRAIN, bk_done=1 SHALL cause transition to IDLE, set rr_ptr = (g+1) mod NUM_REQ and clear grant.
REQ-036 In DRAIN, drain_cnt reaching DRAIN_TIMEOUT-1 without bk_done SHALL set err_timeout and force the same exit as REQ-035.
REQ-037 bk_done arriving in IDLE or XFER SHALL be ignored.
REQ-038 When err_clr and a timeout event occur in the same cycle, set SHALL win.
REQ-039 bk_nordy SHALL affect only XFER acceptance; it SHALL NOT change state.

Reset
REQ-040 While axi_aresetn=0: the state SHALL be IDLE.
REQ-041 While axi_aresetn=0: rr_ptr, beat_cnt and drain_cnt SHALL be 0.
REQ-042 While axi_aresetn=0: grant, req_ready, bk_start, all bk_* outputs and err_timeout SHALL be 0.
REQ-043 Reset asserted mid-XFER or mid-DRAIN SHALL abort immediately with no further beats.
REQ-044 After release, arbitration SHALL restart from requester 0.

Verification
REQ-045 Scenario: req0 sends 3 beats 0xA0..0xA2, last on the third; bk_done is pulsed 2 cycles later. Required: 3 bk_start pulses with bk_user=0; grant=001 through DRAIN; rr_ptr=1 afterward.
REQ-046 Scenario: req0, req1 and req2 are held valid with 1-beat packets. Required: grant sequence 001, 010, 100, 001 (round-robin).
REQ-047 Scenario: req1 sends a 9-beat packet. Required: split into 6 beats then 3 beats, each part followed by DRAIN, with the other requesters idle between parts.
REQ-048 Scenario: bk_nordy high for 4 cycles mid-packet. Required: req_ready=0 and bk_start=0 for exactly those cycles; data order is preserved.
REQ-049 Scenario: bk_done is withheld in DRAIN. Required: err_timeout=1 after 64 cycles, return to IDLE; err_clr then clears it.
REQ-050 Scenario: axi_aresetn pulsed low during beat 2 of 4. Required: all outputs 0 immediately; the next grant goes to the lowest-index valid requester.

Source files
------------

// File: rtl/axis_bk_arbiter_if.sv
// Bundle of requester-side AXI-Stream beats and backend write-port signals
// for the round-robin backend arbiter. The arbiter takes the slave view.
interface axis_bk_arbiter_if #(
  parameter int NUM_REQ = 3
);
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ*32-1:0] req_data;
  logic [NUM_REQ*4-1:0]  req_tstrb;
  logic [NUM_REQ*4-1:0]  req_tkeep;
  logic [NUM_REQ-1:0]    req_last;
  logic [NUM_REQ-1:0]    req_ready;
  logic [NUM_REQ-1:0]    grant;
  logic                  bk_start;
  logic [31:0]           bk_data;
  logic [3:0]            bk_tstrb;
  logic [3:0]            bk_tkeep;
  logic [1:0]            bk_user;
  logic                  bk_nordy;
  logic                  bk_done;
  logic                  err_timeout;
  logic                  err_clr;

  modport slave (
    input  req_valid, req_data, req_tstrb, req_tkeep, req_last,
    input  bk_nordy, bk_done, err_clr,
    output req_ready, grant, bk_start, bk_data, bk_tstrb, bk_tkeep, bk_user,
    output err_timeout
  );

  modport master (
    output req_valid, req_data, req_tstrb, req_tkeep, req_last,
    output bk_nordy, bk_done, err_clr,
    input  req_ready, grant, bk_start, bk_data, bk_tstrb, bk_tkeep, bk_user,
    input  err_timeout
  );
endinterface

// File: rtl/axis_bk_arbiter.sv
// Round-robin arbiter granting one of NUM_REQ AXI-Stream requesters access
// to a backend write port. Packets longer than MAX_BEATS are split so the
// backend FIFO never overflows; each grant ends with a drain phase that
// waits for bk_done, bounded by DRAIN_TIMEOUT.
module axis_bk_arbiter #(
  parameter int         NUM_REQ       = 3,
  parameter int         MAX_BEATS     = 6,
  parameter logic [7:0] DRAIN_TIMEOUT = 8'd64
) (
  input logic              axi_aclk,
  input logic              axi_aresetn,
  axis_bk_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    XFER  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [NUM_REQ-1:0] grant_q;
  logic [1:0]         g_idx_q;
  logic [1:0]         rr_ptr_q;
  logic [3:0]         beat_cnt_q;
  logic [7:0]         drain_cnt_q;
  logic               err_q;

  logic        sel_found;
  logic [1:0]  sel_idx;
  logic [2:0]  idx;
  logic        cur_valid;
  logic        cur_last;
  logic [31:0] cur_data;
  logic [3:0]  cur_tstrb;
  logic [3:0]  cur_tkeep;
  logic        accept;
  logic        xfer_end;
  logic        drain_exit;
  logic        timeout_evt;
  logic [1:0]  rr_next;

  // Pick the first valid requester at or after rr_ptr, wrapping modulo NUM_REQ.
  // NOTE: every variable driven here gets a default first so no latch is inferred.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = 2'd0;
    idx       = 3'd0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = 3'(rr_ptr_q) + 3'(k);
      if (idx >= 3'(NUM_REQ)) idx = idx - 3'(NUM_REQ);
      if (!sel_found && bus.req_valid[idx]) begin
        sel_found = 1'b1;
        sel_idx   = idx[1:0];
      end
    end
  end

  // Select the granted requester's beat fields.
  always_comb begin
    cur_valid = 1'b0;
    cur_last  = 1'b0;
    cur_data  = 32'd0;
    cur_tstrb = 4'd0;
    cur_tkeep = 4'd0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (g_idx_q == 2'(i)) begin
        cur_valid = bus.req_valid[i];
        cur_last  = bus.req_last[i];
        cur_data  = bus.req_data[i*32 +: 32];
        cur_tstrb = bus.req_tstrb[i*4 +: 4];
        cur_tkeep = bus.req_tkeep[i*4 +: 4];
      end
    end
  end

  assign rr_next = (g_idx_q == 2'(NUM_REQ - 1)) ? 2'd0 : g_idx_q + 2'd1;

  // Next-state logic and per-cycle events for the IDLE/XFER/DRAIN sequence.
  always_comb begin
    state_d     = state_q;
    accept      = 1'b0;
    xfer_end    = 1'b0;
    drain_exit  = 1'b0;
    timeout_evt = 1'b0;
    case (state_q)
      IDLE: begin
        if (sel_found) state_d = XFER;
      end
      XFER: begin
        accept = cur_valid & ~bus.bk_nordy;
        // Last beat and the beat-limit split collapse into one transition.
        if (accept && (cur_last || beat_cnt_q == 4'(MAX_BEATS - 1))) begin
          xfer_end = 1'b1;
          state_d  = DRAIN;
        end
      end
      DRAIN: begin
        if (bus.bk_done) begin
          drain_exit = 1'b1;
        end else if (drain_cnt_q == DRAIN_TIMEOUT - 8'd1) begin
          timeout_evt = 1'b1;
          drain_exit  = 1'b1;
        end
        if (drain_exit) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register.
  // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) state_q <= IDLE;
    else              state_q <= state_d;
  end

  // Grant owner, round-robin pointer and the beat/drain counters.
  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      grant_q     <= '0;
      g_idx_q     <= 2'd0;
      rr_ptr_q    <= 2'd0;
      beat_cnt_q  <= 4'd0;
      drain_cnt_q <= 8'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (sel_found) begin
            grant_q    <= {{(NUM_REQ-1){1'b0}}, 1'b1} << sel_idx;
            g_idx_q    <= sel_idx;
            beat_cnt_q <= 4'd0;
          end
        end
        XFER: begin
          if (accept)   beat_cnt_q  <= beat_cnt_q + 4'd1;
          if (xfer_end) drain_cnt_q <= 8'd0;
        end
        DRAIN: begin
          if (drain_exit) begin
            grant_q  <= '0;
            rr_ptr_q <= rr_next;
          end else begin
            drain_cnt_q <= drain_cnt_q + 8'd1;
          end
        end
        default: grant_q <= '0;
      endcase
    end
  end

  // Sticky drain-timeout flag; a timeout in the same cycle as err_clr wins.
  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn)     err_q <= 1'b0;
    else if (timeout_evt) err_q <= 1'b1;
    else if (bus.err_clr) err_q <= 1'b0;
  end

  assign bus.req_ready   = (state_q == XFER) ? (grant_q & {NUM_REQ{~bus.bk_nordy}}) : '0;
  assign bus.grant       = grant_q;
  assign bus.bk_start    = accept;
  assign bus.bk_data     = accept ? cur_data  : 32'd0;
  assign bus.bk_tstrb    = accept ? cur_tstrb : 4'd0;
  assign bus.bk_tkeep    = accept ? cur_tkeep : 4'd0;
  assign bus.bk_user     = accept ? g_idx_q   : 2'd0;
  assign bus.err_timeout = err_q;

endmodule

// File: tb/tb_axis_bk_arbiter.sv
// Directed bench for axis_bk_arbiter: per-requester beat sources, a queue of
// expected backend beats filled at load time, and grant-order logging.
module tb_axis_bk_arbiter;
  localparam int N = 3;

  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  always #5 aclk = ~aclk;

  axis_bk_arbiter_if #(.NUM_REQ(N)) bus ();

  axis_bk_arbiter #(
    .NUM_REQ      (N),
    .MAX_BEATS    (6),
    .DRAIN_TIMEOUT(8'd64)
  ) dut (
    .axi_aclk   (aclk),
    .axi_aresetn(aresetn),
    .bus        (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [41:0]  exp_q[$];
  logic [N-1:0] grant_seq[$];
  logic [N-1:0] prev_grant;
  logic [31:0]  src_data [N][16];
  logic         src_last [N][16];
  int           src_len  [N];
  int           src_pos  [N];
  logic [N-1:0] obs_ready, obs_grant;
  logic         obs_start, obs_drain;
  logic         auto_done;
  int           start_cnt;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Backend word layout: {user, tkeep, tstrb, data}; tstrb/tkeep derive from data.
  function automatic logic [41:0] beat_word(input int r, input logic [31:0] d);
    return {2'(r), d[7:4], d[3:0], d};
  endfunction

  task automatic drive_srcs();
    for (int i = 0; i < N; i++) begin
      if (src_pos[i] < src_len[i]) begin
        bus.req_valid[i]          = 1'b1;
        bus.req_data[i*32 +: 32]  = src_data[i][src_pos[i]];
        bus.req_tstrb[i*4 +: 4]   = src_data[i][src_pos[i]][3:0];
        bus.req_tkeep[i*4 +: 4]   = src_data[i][src_pos[i]][7:4];
        bus.req_last[i]           = src_last[i][src_pos[i]];
      end else begin
        bus.req_valid[i]          = 1'b0;
        bus.req_data[i*32 +: 32]  = 32'd0;
        bus.req_tstrb[i*4 +: 4]   = 4'd0;
        bus.req_tkeep[i*4 +: 4]   = 4'd0;
        bus.req_last[i]           = 1'b0;
      end
    end
  endtask

  task automatic clear_srcs();
    for (int i = 0; i < N; i++) begin
      src_len[i] = 0;
      src_pos[i] = 0;
    end
    grant_seq.delete();
    start_cnt = 0;
  endtask

  task automatic load_pkt(input int r, input logic [31:0] base, input int n);
    for (int k = 0; k < n; k++) begin
      src_data[r][src_len[r]] = base + 32'(k);
      src_last[r][src_len[r]] = (k == n - 1);
      src_len[r]++;
      exp_q.push_back(beat_word(r, base + 32'(k)));
    end
  endtask

  function automatic bit srcs_empty();
    for (int i = 0; i < N; i++) if (src_pos[i] < src_len[i]) return 1'b0;
    return 1'b1;
  endfunction

  // One clock: sample at negedge, advance sources and drive just after posedge.
  task automatic tick();
    logic [N-1:0] acc;
    @(negedge aclk);
    obs_ready = bus.req_ready;
    obs_grant = bus.grant;
    obs_start = bus.bk_start;
    obs_drain = (bus.grant != '0) && (bus.req_ready == '0) && !bus.bk_nordy;
    acc = bus.req_valid & bus.req_ready;
    if (bus.bk_start) begin
      start_cnt++;
      if (exp_q.size() == 0) check("bk_unexpected_beat", 64'd1, 64'd0);
      else check("bk_beat", {bus.bk_user, bus.bk_tkeep, bus.bk_tstrb, bus.bk_data}, exp_q.pop_front());
    end else begin
      check("bk_idle_zero", {bus.bk_user, bus.bk_tkeep, bus.bk_tstrb, bus.bk_data}, 64'd0);
    end
    if (obs_grant != '0 && obs_grant != prev_grant) grant_seq.push_back(obs_grant);
    prev_grant = obs_grant;
    @(posedge aclk);
    #1;
    for (int i = 0; i < N; i++) if (acc[i]) src_pos[i]++;
    bus.bk_done = auto_done && obs_drain && !bus.bk_done;
    drive_srcs();
  endtask

  task automatic run_until_done(input int budget, input string tag);
    int n = 0;
    while (n < budget && !(exp_q.size() == 0 && srcs_empty() && bus.grant == '0)) begin
      tick();
      n++;
    end
    check({tag, "_budget"}, 64'(n < budget), 64'd1);
  endtask

  task automatic wait_drain(input int budget, input string tag);
    int n = 0;
    obs_drain = 1'b0;
    while (n < budget && !obs_drain) begin
      tick();
      n++;
    end
    check({tag, "_drain_seen"}, 64'(obs_drain), 64'd1);
  endtask

  task automatic check_grants(input string tag, input int cnt, input logic [11:0] expv);
    check({tag, "_count"}, 64'(grant_seq.size()), 64'(cnt));
    for (int i = 0; i < cnt && i < grant_seq.size(); i++)
      check({tag, "_order"}, 64'(grant_seq[i]), 64'(expv[i*3 +: 3]));
  endtask

  initial begin
    #200000;
    $fatal(1, "FAIL watchdog: simulation time limit reached");
  end

  initial begin
    bus.req_valid = '0; bus.req_data = '0; bus.req_tstrb = '0; bus.req_tkeep = '0;
    bus.req_last = '0; bus.bk_nordy = 1'b0; bus.bk_done = 1'b0; bus.err_clr = 1'b0;
    auto_done = 1'b0; prev_grant = '0; obs_drain = 1'b0;
    clear_srcs();

    // Reset state.
    tick(); tick();
    check("rst_grant", 64'(bus.grant), 64'd0);
    check("rst_ready", 64'(bus.req_ready), 64'd0);
    check("rst_start", 64'(bus.bk_start), 64'd0);
    check("rst_err",   64'(bus.err_timeout), 64'd0);
    aresetn = 1'b1;

    // req0: 3 beats, bk_done two cycles after the last beat.
    clear_srcs();
    load_pkt(0, 32'h0000_00A0, 3);
    drive_srcs();
    begin
      int n = 0;
      while (n < 10 && !srcs_empty()) begin tick(); n++; end
      check("s1_budget", 64'(n < 10), 64'd1);
    end
    check("s1_beats",       64'(start_cnt), 64'd3);
    check("s1_drain_grant", 64'(bus.grant), 64'b001);
    check("s1_drain_ready", 64'(bus.req_ready), 64'd0);
    tick();
    check("s1_drain_grant2", 64'(obs_grant), 64'b001);
    bus.bk_done = 1'b1;
    tick();
    check("s1_idle_grant", 64'(bus.grant), 64'd0);

    // rr_ptr is now 1: req2 must win over req0.
    clear_srcs();
    load_pkt(2, 32'h0000_B200, 1);
    load_pkt(0, 32'h0000_B000, 1);
    drive_srcs();
    auto_done = 1'b1;
    run_until_done(30, "rr1");
    check_grants("rr1", 2, {6'd0, 3'b001, 3'b100});

    // Fresh reset, three requesters held valid with 1-beat packets.
    aresetn = 1'b0;
    tick(); tick();
    aresetn = 1'b1;
    clear_srcs();
    load_pkt(0, 32'h0000_C000, 1);
    load_pkt(1, 32'h0000_C100, 1);
    load_pkt(2, 32'h0000_C200, 1);
    load_pkt(0, 32'h0000_C001, 1);
    drive_srcs();
    tick();
    check("lat_idle_ready", 64'(obs_ready), 64'd0);
    check("lat_idle_grant", 64'(obs_grant), 64'd0);
    tick();
    check("lat_xfer_ready", 64'(obs_ready), 64'b001);
    run_until_done(40, "rr_all");
    check_grants("rr_all", 4, {3'b001, 3'b100, 3'b010, 3'b001});

    // req1: 9-beat packet, split 6 + 3.
    clear_srcs();
    load_pkt(1, 32'h0000_1100, 9);
    drive_srcs();
    wait_drain(20, "split1");
    check("split_first_part", 64'(src_pos[1]), 64'd6);
    check("split_first_cnt",  64'(start_cnt), 64'd6);
    run_until_done(40, "split2");
    check("split_total", 64'(start_cnt), 64'd9);
    check_grants("split", 2, {6'd0, 3'b010, 3'b010});

    // Back-pressure for 4 cycles mid-packet; stray bk_done in XFER is ignored.
    clear_srcs();
    load_pkt(0, 32'h0000_C000, 6);
    drive_srcs();
    tick(); tick(); tick();
    bus.bk_nordy = 1'b1;
    for (int k = 0; k < 4; k++) begin
      if (k == 1) bus.bk_done = 1'b1;
      tick();
      check("nordy_ready", 64'(obs_ready), 64'd0);
      check("nordy_start", 64'(obs_start), 64'd0);
      check("nordy_grant", 64'(obs_grant), 64'b001);
    end
    bus.bk_nordy = 1'b0;
    check("nordy_hold_pos", 64'(src_pos[0]), 64'd2);
    tick();
    check("nordy_resume_ready", 64'(obs_ready), 64'b001);
    check("nordy_resume_start", 64'(obs_start), 64'd1);
    run_until_done(40, "nordy");

    // Withheld bk_done: timeout after 64 DRAIN cycles, then err_clr.
    auto_done = 1'b0;
    clear_srcs();
    load_pkt(2, 32'h0000_D200, 1);
    drive_srcs();
    wait_drain(10, "to1");
    repeat (62) tick();
    check("to_err_before", 64'(bus.err_timeout), 64'd0);
    check("to_grant_before", 64'(bus.grant), 64'b100);
    tick();
    check("to_err_set", 64'(bus.err_timeout), 64'd1);
    check("to_grant_exit", 64'(bus.grant), 64'd0);
    repeat (3) tick();
    check("to_err_sticky", 64'(bus.err_timeout), 64'd1);
    bus.err_clr = 1'b1;
    tick();
    bus.err_clr = 1'b0;
    check("to_err_clr", 64'(bus.err_timeout), 64'd0);

    // Timeout coinciding with err_clr: set wins.
    clear_srcs();
    load_pkt(2, 32'h0000_D201, 1);
    drive_srcs();
    wait_drain(10, "to2");
    bus.err_clr = 1'b1;
    repeat (62) tick();
    check("to2_err_before", 64'(bus.err_timeout), 64'd0);
    tick();
    check("to2_set_wins", 64'(bus.err_timeout), 64'd1);
    tick();
    check("to2_clr_after", 64'(bus.err_timeout), 64'd0);
    bus.err_clr = 1'b0;

    // bk_done in IDLE is ignored.
    bus.bk_done = 1'b1;
    tick();
    check("idle_done_grant", 64'(bus.grant), 64'd0);
    check("idle_done_err",   64'(bus.err_timeout), 64'd0);

    // Move rr_ptr to 2, then reset during beat 2 of 4.
    auto_done = 1'b1;
    clear_srcs();
    load_pkt(1, 32'h0000_E100, 1);
    drive_srcs();
    run_until_done(20, "pre_rst");
    clear_srcs();
    load_pkt(1, 32'h0000_F100, 4);
    drive_srcs();
    tick(); tick();
    check("mid_beat2_start", 64'(bus.bk_start), 64'd1);
    aresetn = 1'b0;
    #1;
    check("mid_rst_grant", 64'(bus.grant), 64'd0);
    check("mid_rst_ready", 64'(bus.req_ready), 64'd0);
    check("mid_rst_start", 64'(bus.bk_start), 64'd0);
    check("mid_rst_bk", {bus.bk_user, bus.bk_tkeep, bus.bk_tstrb, bus.bk_data}, 64'd0);
    exp_q.delete();
    clear_srcs();
    drive_srcs();
    tick(); tick();
    aresetn = 1'b1;
    clear_srcs();
    load_pkt(1, 32'h0000_1F00, 1);
    load_pkt(2, 32'h0000_2F00, 1);
    drive_srcs();
    run_until_done(30, "post_rst");
    check_grants("post_rst", 2, {6'd0, 3'b100, 3'b010});

    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
